seg_scan_monitor: RTL and testbench

- Receive-side monitor for the multiplexed 7-segment display bus: the same active-low segment lines and one-hot digit selects that drive the board's display.
- Waits for each selected digit's pattern to be stable for a programmable number of cycles, then decodes the pattern back to a BCD digit and holds the result per digit position.
- Used for on-board loopback self-test of the score/display path and as a stimulus checker in system benches.
- Flags patterns that are neither a legal digit nor blank.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_scan_monitor_if.sv | 22 ++
 rtl/seg_pattern_decode.sv | 34 +++
 rtl/seg_scan_monitor.sv | 132 +++++++++++++
 tb/tb_seg_scan_monitor.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment code table (active-low, bit 6 = g .. bit 0 = a) used by both the
// display encoder and the scan monitor, plus the monitor's FSM state type.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } mon_state_t;

endpackage

// File: rtl/seg_scan_monitor_if.sv
// Multiplexed 7-segment bus as seen by a display driver (master) and the scan monitor (slave).
interface seg_scan_monitor_if #(
  parameter int NUM_DIGITS = 2
);
  logic [6:0]              segment;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   valid;
  logic                    update;
  logic                    error;
  logic [7:0]              error_count;

  modport master (
    output segment, digit_sel,
    input  digits, valid, update, error, error_count
  );

  modport slave (
    input  segment, digit_sel,
    output digits, valid, update, error, error_count
  );
endinterface

// File: rtl/seg_pattern_decode.sv
// Inverse of the display table: active-low segment pattern -> BCD digit, blank or illegal.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       is_digit,
  output logic       is_blank,
  output logic [3:0] bcd
);

  always_comb begin
    is_digit = 1'b1;
    is_blank = 1'b0;
    bcd      = BCD_BLANK;
    case (pattern)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_monitor.sv
// Receive-side monitor for the multiplexed 7-segment bus: waits for a stable selected
// pattern, decodes it and holds the BCD result per digit position.
//
// state   | meaning
// IDLE    | sampled select is zero or not one-hot; nothing is captured
// SETTLE  | one-hot select seen, counting identical samples
// CAPTURE | single cycle: decode the sample and write the selected position
// HOLD    | captured; wait for the sample to change
module seg_scan_monitor
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 16
) (
  input logic              i_Clk,
  input logic              i_Rst_L,
  seg_scan_monitor_if.slave bus
);

  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0]              s_seg;
  logic [NUM_DIGITS-1:0]   s_sel;
  logic [7:0]              cnt;
  mon_state_t              state, state_nxt;
  logic                    capture;

  logic [4*NUM_DIGITS-1:0] digits_q, digits_nxt;
  logic [NUM_DIGITS-1:0]   valid_q, valid_nxt;
  logic                    update_q, error_q, err_hit;
  logic [7:0]              err_cnt_q;

  logic                    dec_digit, dec_blank;
  logic [3:0]              dec_bcd;

  // Compare against the incoming sample so counter and FSM react on the edge that loads S.
  logic changed, in_onehot;
  assign changed   = (bus.segment != s_seg) || (bus.digit_sel != s_sel);
  assign in_onehot = $onehot(bus.digit_sel);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      s_seg <= SEG_BLANK;
      s_sel <= '0;
      cnt   <= '0;
      state <= IDLE;
    end else begin
      s_seg <= bus.segment;
      s_sel <= bus.digit_sel;
      if (changed)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 8'd1;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      IDLE:
        if (in_onehot) state_nxt = SETTLE;
      SETTLE:
        if (changed)               state_nxt = in_onehot ? SETTLE : IDLE;
        else if (cnt == CNT_LAST)  state_nxt = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        // A change arriving on the capture edge must not be lost in HOLD.
        if (changed) state_nxt = in_onehot ? SETTLE : IDLE;
        else         state_nxt = HOLD;
      end
      HOLD:
        if (changed) state_nxt = in_onehot ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  seg_pattern_decode u_decode (
    .pattern  (s_seg),
    .is_digit (dec_digit),
    .is_blank (dec_blank),
    .bcd      (dec_bcd)
  );

  always_comb begin
    digits_nxt = digits_q;
    valid_nxt  = valid_q;
    err_hit    = 1'b0;
    if (capture) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (s_sel[k]) begin
          if (dec_digit) begin
            digits_nxt[4*k +: 4] = dec_bcd;
            valid_nxt[k]         = 1'b1;
          end else if (dec_blank) begin
            digits_nxt[4*k +: 4] = BCD_BLANK;
            valid_nxt[k]         = 1'b0;
          end else begin
            valid_nxt[k]         = 1'b0;
          end
        end
      end
      err_hit = !dec_digit && !dec_blank;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      digits_q  <= {NUM_DIGITS{BCD_BLANK}};
      valid_q   <= '0;
      update_q  <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      digits_q <= digits_nxt;
      valid_q  <= valid_nxt;
      update_q <= (digits_nxt != digits_q) || (valid_nxt != valid_q);
      error_q  <= err_hit;
      if (err_hit && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.valid       = valid_q;
  assign bus.update      = update_q;
  assign bus.error       = error_q;
  assign bus.error_count = err_cnt_q;

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Randomized and directed bench for seg_scan_monitor, checked every cycle against a
// run-length reference model of the capture rules.
module tb_seg_scan_monitor;

  localparam int ND = 2;
  localparam int SC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_monitor_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_monitor #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [6:0] tbl [10];

  // reference model state
  logic [3:0] m_digit [ND];
  logic       m_valid [ND];
  int         m_errs;
  logic       m_upd, m_err;
  logic [8:0] last_v;
  int         run;
  logic       pend;
  logic [8:0] pend_v;

  int upd_seen, err_seen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_decode(input logic [6:0] p);
    if (p == 7'h7F) return 10;
    for (int i = 0; i < 10; i++)
      if (tbl[i] == p) return i;
    return 11;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_digit[i] = 4'hF;
      m_valid[i] = 1'b0;
    end
    m_errs = 0;
    m_upd  = 1'b0;
    m_err  = 1'b0;
    last_v = {2'b00, 7'h7F};
    run    = 0;
    pend   = 1'b0;
    pend_v = '0;
  endtask

  // A value sampled on SC+1 consecutive edges with a one-hot select is written one edge later.
  task automatic model_edge(input logic [1:0] sel, input logic [6:0] seg);
    int pos, code;
    logic [3:0] old_d;
    logic old_v;
    m_upd = 1'b0;
    m_err = 1'b0;
    if (pend) begin
      pos   = pend_v[8] ? 1 : 0;
      code  = model_decode(pend_v[6:0]);
      old_d = m_digit[pos];
      old_v = m_valid[pos];
      if (code < 10) begin
        m_digit[pos] = 4'(code);
        m_valid[pos] = 1'b1;
      end else if (code == 10) begin
        m_digit[pos] = 4'hF;
        m_valid[pos] = 1'b0;
      end else begin
        m_valid[pos] = 1'b0;
        m_err = 1'b1;
        if (m_errs < 255) m_errs++;
      end
      m_upd = (old_d != m_digit[pos]) || (old_v != m_valid[pos]);
      pend  = 1'b0;
    end
    if ({sel, seg} == last_v) run++;
    else run = 1;
    last_v = {sel, seg};
    if (run == SC + 1 && (sel == 2'b01 || sel == 2'b10)) begin
      pend   = 1'b1;
      pend_v = last_v;
    end
  endtask

  task automatic compare_all();
    check_val("digits",  32'(bus.digits), 32'({m_digit[1], m_digit[0]}));
    check_val("valid",   32'(bus.valid), 32'({m_valid[1], m_valid[0]}));
    check_val("update",  32'(bus.update), 32'(m_upd));
    check_val("error",   32'(bus.error), 32'(m_err));
    check_val("err_cnt", 32'(bus.error_count), 32'(m_errs));
  endtask

  task automatic tick(input logic [1:0] sel, input logic [6:0] seg);
    bus.digit_sel = sel;
    bus.segment   = seg;
    @(posedge clk);
    model_edge(sel, seg);
    @(negedge clk);
    compare_all();
    if (bus.update === 1'b1) upd_seen++;
    if (bus.error === 1'b1) err_seen++;
  endtask

  task automatic hold(input logic [1:0] sel, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) tick(sel, seg);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_digits",  32'(bus.digits), 32'h0000_00FF);
    check_val("rst_valid",   32'(bus.valid), 32'h0);
    check_val("rst_update",  32'(bus.update), 32'h0);
    check_val("rst_error",   32'(bus.error), 32'h0);
    check_val("rst_err_cnt", 32'(bus.error_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] rsel;
    logic [6:0] rseg;
    int r;

    tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
    tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
    tbl[6] = 7'b0000010; tbl[7] = 7'b1111000; tbl[8] = 7'b0000000;
    tbl[9] = 7'b0010000;

    bus.digit_sel = '0;
    bus.segment   = 7'h7F;
    model_reset();
    do_reset();

    // digit 2 on position 0: written 17 edges after the first sample
    upd_seen = 0; err_seen = 0;
    hold(2'b01, tbl[2], 17);
    check_val("t1_before", 32'(bus.digits[3:0]), 32'hF);
    tick(2'b01, tbl[2]);
    check_val("t1_digit", 32'(bus.digits[3:0]), 32'h2);
    check_val("t1_valid", 32'(bus.valid[0]), 32'h1);
    hold(2'b01, tbl[2], 2);
    check_val("t1_upd_cnt", 32'(upd_seen), 32'd1);
    check_val("t1_err_cnt", 32'(err_seen), 32'd0);

    // short 9 never captured, then 1 on position 1
    upd_seen = 0;
    hold(2'b10, tbl[9], 10);
    hold(2'b10, tbl[1], 20);
    check_val("t2_digit", 32'(bus.digits[7:4]), 32'h1);
    check_val("t2_upd_cnt", 32'(upd_seen), 32'd1);

    // alternating scan of 4 / 7
    upd_seen = 0;
    for (int rnd = 0; rnd < 4; rnd++) begin
      hold(2'b01, tbl[4], 32);
      hold(2'b10, tbl[7], 32);
    end
    check_val("t3_digits", 32'(bus.digits), 32'h74);
    check_val("t3_valid", 32'(bus.valid), 32'h3);
    check_val("t3_upd_cnt", 32'(upd_seen), 32'd2);

    // illegal pattern, then saturation of the error count
    err_seen = 0;
    hold(2'b01, 7'b1010101, 20);
    check_val("t4_err_cnt", 32'(bus.error_count), 32'd1);
    check_val("t4_err_pulses", 32'(err_seen), 32'd1);
    check_val("t4_valid0", 32'(bus.valid[0]), 32'h0);
    check_val("t4_digit0", 32'(bus.digits[3:0]), 32'h4);
    for (int i = 0; i < 300; i++)
      hold((i % 2 == 0) ? 2'b10 : 2'b01, 7'b1010101, 20);
    check_val("t4_sat", 32'(bus.error_count), 32'd255);

    // non-one-hot select never captures
    do_reset();
    upd_seen = 0; err_seen = 0;
    hold(2'b11, tbl[0], 50);
    check_val("t5_upd_cnt", 32'(upd_seen), 32'd0);
    check_val("t5_err_cnt", 32'(err_seen), 32'd0);
    check_val("t5_digits", 32'(bus.digits), 32'hFF);

    // reset mid-settle discards the partial count
    hold(2'b01, tbl[5], 10);
    do_reset();
    hold(2'b01, tbl[5], 17);
    check_val("t6_before", 32'(bus.digits[3:0]), 32'hF);
    tick(2'b01, tbl[5]);
    check_val("t6_digit", 32'(bus.digits[3:0]), 32'h5);

    // randomized scan traffic
    for (int seg_i = 0; seg_i < 200; seg_i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)       rseg = tbl[$urandom_range(0, 9)];
      else if (r == 6)  rseg = 7'h7F;
      else              rseg = 7'($urandom);
      r = int'($urandom_range(0, 7));
      if (r < 3)        rsel = 2'b01;
      else if (r < 6)   rsel = 2'b10;
      else if (r == 6)  rsel = 2'b00;
      else              rsel = 2'b11;
      hold(rsel, rseg, int'($urandom_range(1, 24)));
      if ($urandom_range(0, 49) == 0) do_reset();
    end
    hold(2'b00, 7'h7F, 3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
